// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock serial datapath (transmitter and receiver).
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } lock_tx_state_t;

  localparam logic [3:0] LOCK_CODE_DEFAULT = 4'b0110;
  localparam logic       LOCK_IDLE_LEVEL   = 1'b1;

  // Largest of three values; used to size down-counters shared by several phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_code_tx_if.sv
// Request/serial-line bundle between a code source and the lock code transmitter.
interface lock_code_tx_if #(
  parameter int CODE_W = 4
);
  logic              start;
  logic [CODE_W-1:0] code;
  logic              tx_bit;
  logic              busy;
  logic              done;

  // Requester side: issues start/code, observes the line and status.
  modport master (output start, output code, input tx_bit, input busy, input done);
  // Transmitter side.
  modport slave  (input start, input code, output tx_bit, output busy, output done);
endinterface

// File: rtl/lock_code_shreg.sv
// Parallel-load, shift-left register; msb is the next bit to go out on the line.
module lock_code_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg_reg;

  // Load takes priority over shift; zeros fill from the right.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_reg <= '0;
    end else if (load) begin
      shreg_reg <= din;
    end else if (shift) begin
      shreg_reg <= {shreg_reg[W-2:0], 1'b0};
    end
  end

  assign msb = shreg_reg[W-1];

endmodule

// File: rtl/lock_code_tx.sv
// Serial code transmitter: guard run of idle-level bits, then the code MSB first,
// then a one-cycle done pulse. All outputs come straight from flops.
module lock_code_tx
  import lock_pkg::*;
#(
  parameter int   CODE_W     = 4,
  parameter int   GUARD_CYC  = 2,
  parameter logic IDLE_LEVEL = LOCK_IDLE_LEVEL
) (
  input  logic           clk,
  input  logic           reset,
  lock_code_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(max3(CODE_W, GUARD_CYC, 2));

  lock_tx_state_t   state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             tx_bit_reg;
  logic             busy_reg;
  logic             done_reg;

  logic              shreg_load;
  logic              shreg_shift;
  logic [CODE_W-1:0] shreg_din;
  logic              shreg_msb;

  // The shift register always holds the bits not yet placed on the line. With no
  // guard phase the MSB goes straight into tx_bit on the accepting edge, so it is
  // dropped from the loaded value.
  assign shreg_load  = (state_reg == IDLE) && bus.start;
  assign shreg_shift = ((state_reg == GUARD) && (cnt_reg == '0)) ||
                       ((state_reg == SEND)  && (cnt_reg != '0));
  assign shreg_din   = (GUARD_CYC == 0) ? {bus.code[CODE_W-2:0], 1'b0} : bus.code;

  lock_code_shreg #(.W(CODE_W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (shreg_load),
    .shift (shreg_shift),
    .din   (shreg_din),
    .msb   (shreg_msb)
  );

  // Frame sequencer with registered Moore outputs; counters reload on each state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      tx_bit_reg <= IDLE_LEVEL;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_bit_reg <= IDLE_LEVEL;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
          if (bus.start) begin
            busy_reg <= 1'b1;
            if (GUARD_CYC > 0) begin
              state_reg <= GUARD;
              cnt_reg   <= CNT_W'(GUARD_CYC - 1);
            end else begin
              state_reg  <= SEND;
              cnt_reg    <= CNT_W'(CODE_W - 1);
              tx_bit_reg <= bus.code[CODE_W-1];
            end
          end
        end
        GUARD: begin
          if (cnt_reg == '0) begin
            state_reg  <= SEND;
            cnt_reg    <= CNT_W'(CODE_W - 1);
            tx_bit_reg <= shreg_msb;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        SEND: begin
          if (cnt_reg == '0) begin
            state_reg  <= DONE;
            tx_bit_reg <= IDLE_LEVEL;
            done_reg   <= 1'b1;
          end else begin
            cnt_reg    <= cnt_reg - 1'b1;
            tx_bit_reg <= shreg_msb;
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          tx_bit_reg <= IDLE_LEVEL;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          tx_bit_reg <= IDLE_LEVEL;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_bit = tx_bit_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_lock_code_tx.sv
// Directed bench for lock_code_tx: default config, zero-guard config and 8-bit code config.
module tb_lock_code_tx;
  import lock_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lock_code_tx_if #(.CODE_W(4)) if0 ();
  lock_code_tx_if #(.CODE_W(4)) if1 ();
  lock_code_tx_if #(.CODE_W(8)) if2 ();

  lock_code_tx #(.CODE_W(4), .GUARD_CYC(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  lock_code_tx #(.CODE_W(4), .GUARD_CYC(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  lock_code_tx #(.CODE_W(8), .GUARD_CYC(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0]  exp_tx7;
  logic [6:0]  exp_done7;
  logic [4:0]  exp_tx5;
  logic [7:0]  exp_tx8;
  logic [10:0] exp_tx11;

  initial begin
    reset = 1'b1;
    if0.start = 1'b0; if0.code = LOCK_CODE_DEFAULT;
    if1.start = 1'b0; if1.code = 4'b0000;
    if2.start = 1'b0; if2.code = 8'h00;
    tick();
    tick();
    // Reset state
    chk("reset_tx0",   16'(if0.tx_bit), 16'd1);
    chk("reset_busy0", 16'(if0.busy),   16'd0);
    chk("reset_done0", 16'(if0.done),   16'd0);
    chk("reset_tx1",   16'(if1.tx_bit), 16'd1);
    chk("reset_busy2", 16'(if2.busy),   16'd0);
    reset = 1'b0;
    tick();
    chk("idle_tx0", 16'(if0.tx_bit), 16'd1);

    // Default frame, code 0110; code changed after acceptance must not matter
    exp_tx7   = 7'b1101101;
    exp_done7 = 7'b0000001;
    if0.code = 4'b0110; if0.start = 1'b1;
    tick();
    if0.start = 1'b0; if0.code = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      $display("frame0 cycle %0d: tx=%b busy=%b done=%b", i, if0.tx_bit, if0.busy, if0.done);
      chk($sformatf("f0_tx[%0d]", i),   16'(if0.tx_bit), 16'(exp_tx7[6-i]));
      chk($sformatf("f0_busy[%0d]", i), 16'(if0.busy),   16'd1);
      chk($sformatf("f0_done[%0d]", i), 16'(if0.done),   16'(exp_done7[6-i]));
    end
    tick();
    chk("f0_end_busy", 16'(if0.busy), 16'd0);
    chk("f0_end_done", 16'(if0.done), 16'd0);

    // Zero-guard config, code 1001
    exp_tx5 = 5'b10011;
    if1.code = 4'b1001; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      $display("g0 cycle %0d: tx=%b busy=%b done=%b", i, if1.tx_bit, if1.busy, if1.done);
      chk($sformatf("g0_tx[%0d]", i),   16'(if1.tx_bit), 16'(exp_tx5[4-i]));
      chk($sformatf("g0_busy[%0d]", i), 16'(if1.busy),   16'd1);
      chk($sformatf("g0_done[%0d]", i), 16'(if1.done),   16'(i == 4));
    end
    tick();
    chk("g0_end_busy", 16'(if1.busy), 16'd0);

    // Start pulsed mid-SEND with another code: ignored, not queued
    exp_tx7 = 7'b1110101;
    if0.code = 4'b1010; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        if (i == 3) begin if0.start = 1'b1; if0.code = 4'b0101; end
        tick();
        if0.start = 1'b0;
      end
      $display("ign cycle %0d: tx=%b busy=%b done=%b", i, if0.tx_bit, if0.busy, if0.done);
      chk($sformatf("ign_tx[%0d]", i),   16'(if0.tx_bit), 16'(exp_tx7[6-i]));
      chk($sformatf("ign_busy[%0d]", i), 16'(if0.busy),   16'd1);
      chk($sformatf("ign_done[%0d]", i), 16'(if0.done),   16'(exp_done7[6-i]));
    end
    tick();
    chk("ign_idle_busy", 16'(if0.busy), 16'd0);
    tick();
    chk("ign_noqueue_busy", 16'(if0.busy),   16'd0);
    chk("ign_noqueue_tx",   16'(if0.tx_bit), 16'd1);

    // Start held high: back-to-back frames, one IDLE cycle apart, done every 8 cycles
    exp_tx8 = 8'b11011011;
    if0.code = 4'b0110;
    for (int i = 0; i < 24; i++) begin
      if0.start = (i < 20);
      tick();
      $display("held cycle %0d: tx=%b busy=%b done=%b", i, if0.tx_bit, if0.busy, if0.done);
      chk($sformatf("held_tx[%0d]", i),   16'(if0.tx_bit), 16'(exp_tx8[7 - (i % 8)]));
      chk($sformatf("held_busy[%0d]", i), 16'(if0.busy),   16'((i % 8) != 7));
      chk($sformatf("held_done[%0d]", i), 16'(if0.done),   16'((i % 8) == 6));
    end
    if0.start = 1'b0;
    tick();
    chk("held_after_busy", 16'(if0.busy), 16'd0);

    // Reset during the second SEND bit abandons the frame
    if0.code = 4'b0110; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    tick();
    tick();
    chk("rst_first_bit",  16'(if0.tx_bit), 16'd0);
    tick();
    chk("rst_second_bit", 16'(if0.tx_bit), 16'd1);
    reset = 1'b1;
    tick();
    $display("reset mid-frame: tx=%b busy=%b done=%b", if0.tx_bit, if0.busy, if0.done);
    chk("rst_tx",   16'(if0.tx_bit), 16'd1);
    chk("rst_busy", 16'(if0.busy),   16'd0);
    chk("rst_done", 16'(if0.done),   16'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_nodone[%0d]", i), 16'(if0.done), 16'd0);
      chk($sformatf("rst_nobusy[%0d]", i), 16'(if0.busy), 16'd0);
    end
    exp_tx7 = 7'b1110011;
    if0.code = 4'b1001; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      $display("post-reset cycle %0d: tx=%b busy=%b done=%b", i, if0.tx_bit, if0.busy, if0.done);
      chk($sformatf("pr_tx[%0d]", i),   16'(if0.tx_bit), 16'(exp_tx7[6-i]));
      chk($sformatf("pr_busy[%0d]", i), 16'(if0.busy),   16'd1);
      chk($sformatf("pr_done[%0d]", i), 16'(if0.done),   16'(exp_done7[6-i]));
    end
    tick();
    chk("pr_end_busy", 16'(if0.busy), 16'd0);

    // 8-bit code A5 after two guard bits
    exp_tx11 = 11'b11101001011;
    if2.code = 8'hA5; if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      $display("w8 cycle %0d: tx=%b busy=%b done=%b", i, if2.tx_bit, if2.busy, if2.done);
      chk($sformatf("w8_tx[%0d]", i),   16'(if2.tx_bit), 16'(exp_tx11[10-i]));
      chk($sformatf("w8_busy[%0d]", i), 16'(if2.busy),   16'd1);
      chk($sformatf("w8_done[%0d]", i), 16'(if2.done),   16'(i == 10));
    end
    tick();
    chk("w8_end_busy", 16'(if2.busy), 16'd0);
    chk("w8_end_done", 16'(if2.done), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
